// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, flush FSM states and branch-decode bundle.
package pipeline_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned REG_W_DEF  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

    // Branch decode bundle as produced by the ID decoder (b/bl/br/beq/bne opcodes).
    typedef struct packed {
        logic b;
        logic bl;
        logic br;
        logic beq;
        logic bne;
    } branch_dec_t;

    // Taken decision: unconditional forms always take, conditional forms test equality.
    function automatic logic branch_take(input branch_dec_t dec, input logic eq);
        return dec.b | dec.bl | dec.br | (dec.beq & eq) | (dec.bne & ~eq);
    endfunction

endpackage

// File: rtl/branch_operand_fwd.sv
// Combinational operand forward mux for one branch source register (EX beats MEM beats RF).
module branch_operand_fwd #(
    parameter int unsigned REG_W  = 4,
    parameter int unsigned DATA_W = 16
) (
    input  logic [REG_W-1:0]  idx,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_wr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] operand_c
);

    // r0 is hardwired, so it never takes a forwarded value.
    always_comb begin
        operand_c = rf_data;
        if (ex_wr && (ex_rd == idx) && (idx != '0)) begin
            operand_c = ex_data;
        end else if (mem_wr && (mem_rd == idx) && (idx != '0)) begin
            operand_c = mem_data;
        end
    end

endmodule

// File: rtl/pipeline_flush_ctrl.sv
// Branch resolution in ID with IF/ID NOP insertion for the resolving cycle plus FLUSH_CYCLES more.
module pipeline_flush_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned REG_W        = REG_W_DEF,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              b,
    input  logic              bl,
    input  logic              br,
    input  logic              beq,
    input  logic              bne,
    input  logic              stall,
    input  logic [REG_W-1:0]  ID_rs,
    input  logic [REG_W-1:0]  ID_rt,
    input  logic [DATA_W-1:0] ID_read_data_1,
    input  logic [DATA_W-1:0] ID_read_data_2,
    input  logic [REG_W-1:0]  EX_rt_rd,
    input  logic [REG_W-1:0]  MEM_rt_rd,
    input  logic              EX_reg_write,
    input  logic              MEM_reg_write,
    input  logic [DATA_W-1:0] EX_alu_out,
    input  logic [DATA_W-1:0] MEM_result,
    output logic              IF_ID_sync_nop,
    output logic              branch_taken,
    output logic              flush_busy,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int unsigned CW = (FLUSH_CYCLES == 0) ? 1 : $clog2(FLUSH_CYCLES + 1);

    flush_state_t      state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] op_a_c, op_b_c;
    branch_dec_t       dec;
    logic              take_c;
    logic              accepted_c;

    branch_operand_fwd #(.REG_W(REG_W), .DATA_W(DATA_W)) u_fwd_rs (
        .idx       (ID_rs),
        .rf_data   (ID_read_data_1),
        .ex_rd     (EX_rt_rd),
        .ex_wr     (EX_reg_write),
        .ex_data   (EX_alu_out),
        .mem_rd    (MEM_rt_rd),
        .mem_wr    (MEM_reg_write),
        .mem_data  (MEM_result),
        .operand_c (op_a_c)
    );

    branch_operand_fwd #(.REG_W(REG_W), .DATA_W(DATA_W)) u_fwd_rt (
        .idx       (ID_rt),
        .rf_data   (ID_read_data_2),
        .ex_rd     (EX_rt_rd),
        .ex_wr     (EX_reg_write),
        .ex_data   (EX_alu_out),
        .mem_rd    (MEM_rt_rd),
        .mem_wr    (MEM_reg_write),
        .mem_data  (MEM_result),
        .operand_c (op_b_c)
    );

    assign dec    = {b, bl, br, beq, bne};
    assign take_c = branch_take(dec, op_a_c == op_b_c);

    // State and remaining-flush counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state and NOP/accept outputs; rst_n gating drops the NOP as soon as reset asserts.
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        accepted_c     = 1'b0;
        IF_ID_sync_nop = 1'b0;
        branch_taken   = 1'b0;
        case (state)
            IDLE: begin
                accepted_c = rst_n & take_c & ~stall;
                if (accepted_c && (FLUSH_CYCLES != 0)) begin
                    state_n = FLUSH;
                    cnt_n   = CW'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                IF_ID_sync_nop = 1'b1;
                if (!stall) begin
                    cnt_n = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (accepted_c) begin
            IF_ID_sync_nop = 1'b1;
            branch_taken   = 1'b1;
        end
    end

    assign flush_busy = (state == FLUSH);

    // Saturating count of accepted taken branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_count <= '0;
        end else if (accepted_c && (flush_count != '1)) begin
            flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
// Bench for pipeline_flush_ctrl: three configurations share one stimulus stream and are
// checked every cycle against a per-instance "remaining NOP cycles" model.
module tb_pipeline_flush_ctrl;

    localparam int NI = 3;  // 0: FC=1 CNT_W=16, 1: FC=3 CNT_W=16, 2: FC=0 CNT_W=2

    logic        clk = 1'b0;
    logic        rst_n;
    logic        b, bl, br, beq, bne, stall;
    logic [3:0]  ID_rs, ID_rt, EX_rt_rd, MEM_rt_rd;
    logic        EX_reg_write, MEM_reg_write;
    logic [15:0] rd1, rd2, EX_alu_out, MEM_result;

    logic        nop_a, nop_b, nop_c, tk_a, tk_b, tk_c, bz_a, bz_b, bz_c;
    logic [15:0] fc_a, fc_b;
    logic [1:0]  fc_c;
    logic [NI-1:0] nop, tk, busy;
    logic [15:0] fcnt [NI];

    int n_pass = 0;
    int n_total = 0;

    int          rem  [NI];
    int unsigned mcnt [NI];
    int          nop_seen [NI];
    int          fc_cfg  [NI] = '{1, 3, 0};
    int unsigned max_cfg [NI] = '{32'd65535, 32'd65535, 32'd3};

    always #5 clk = ~clk;

    assign nop = {nop_c, nop_b, nop_a};
    assign tk  = {tk_c, tk_b, tk_a};
    assign busy = {bz_c, bz_b, bz_a};
    always_comb begin
        fcnt[0] = fc_a;
        fcnt[1] = fc_b;
        fcnt[2] = {14'd0, fc_c};
    end

    pipeline_flush_ctrl #(.DATA_W(16), .REG_W(4), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .b(b), .bl(bl), .br(br), .beq(beq), .bne(bne), .stall(stall),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_read_data_1(rd1), .ID_read_data_2(rd2),
        .EX_rt_rd(EX_rt_rd), .MEM_rt_rd(MEM_rt_rd), .EX_reg_write(EX_reg_write),
        .MEM_reg_write(MEM_reg_write), .EX_alu_out(EX_alu_out), .MEM_result(MEM_result),
        .IF_ID_sync_nop(nop_a), .branch_taken(tk_a), .flush_busy(bz_a), .flush_count(fc_a));

    pipeline_flush_ctrl #(.DATA_W(16), .REG_W(4), .FLUSH_CYCLES(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .b(b), .bl(bl), .br(br), .beq(beq), .bne(bne), .stall(stall),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_read_data_1(rd1), .ID_read_data_2(rd2),
        .EX_rt_rd(EX_rt_rd), .MEM_rt_rd(MEM_rt_rd), .EX_reg_write(EX_reg_write),
        .MEM_reg_write(MEM_reg_write), .EX_alu_out(EX_alu_out), .MEM_result(MEM_result),
        .IF_ID_sync_nop(nop_b), .branch_taken(tk_b), .flush_busy(bz_b), .flush_count(fc_b));

    pipeline_flush_ctrl #(.DATA_W(16), .REG_W(4), .FLUSH_CYCLES(0), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .b(b), .bl(bl), .br(br), .beq(beq), .bne(bne), .stall(stall),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_read_data_1(rd1), .ID_read_data_2(rd2),
        .EX_rt_rd(EX_rt_rd), .MEM_rt_rd(MEM_rt_rd), .EX_reg_write(EX_reg_write),
        .MEM_reg_write(MEM_reg_write), .EX_alu_out(EX_alu_out), .MEM_result(MEM_result),
        .IF_ID_sync_nop(nop_c), .branch_taken(tk_c), .flush_busy(bz_c), .flush_count(fc_c));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Value the branch actually compares for a source register.
    function automatic logic [15:0] resolve(input logic [3:0] idx, input logic [15:0] rf);
        if (idx != 0 && EX_reg_write && EX_rt_rd == idx) return EX_alu_out;
        if (idx != 0 && MEM_reg_write && MEM_rt_rd == idx) return MEM_result;
        return rf;
    endfunction

    function automatic logic model_take();
        logic eq;
        eq = (resolve(ID_rs, rd1) == resolve(ID_rt, rd2));
        return b | bl | br | (beq & eq) | (bne & ~eq);
    endfunction

    // Compare every DUT output against the model in the middle of each cycle.
    always @(negedge clk) begin
        logic t, eb, ea;
        t = model_take();
        for (int i = 0; i < NI; i++) begin
            eb = (rem[i] > 0);
            ea = rst_n && !eb && t && !stall;
            check($sformatf("nop[%0d]", i), 32'(nop[i]), 32'(ea || eb));
            check($sformatf("taken[%0d]", i), 32'(tk[i]), 32'(ea));
            check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(eb));
            check($sformatf("count[%0d]", i), 32'(fcnt[i]), mcnt[i]);
            if (nop[i] === 1'b1) nop_seen[i]++;
        end
    end

    // Model update: an accepted branch books FLUSH_CYCLES more NOP cycles, consumed only when not stalled.
    always @(posedge clk or negedge rst_n) begin
        logic t;
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                rem[i] = 0;
                mcnt[i] = 0;
            end
        end else begin
            t = model_take();
            for (int i = 0; i < NI; i++) begin
                if (rem[i] > 0) begin
                    if (!stall) rem[i]--;
                end else if (t && !stall) begin
                    rem[i] = fc_cfg[i];
                    if (mcnt[i] < max_cfg[i]) mcnt[i]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {b, bl, br, beq, bne, stall} = '0;
        ID_rs = '0; ID_rt = '0; EX_rt_rd = '0; MEM_rt_rd = '0;
        EX_reg_write = 1'b0; MEM_reg_write = 1'b0;
        rd1 = '0; rd2 = '0; EX_alu_out = '0; MEM_result = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic zero_seen();
        for (int i = 0; i < NI; i++) nop_seen[i] = 0;
    endtask

    // Set inputs, then check dut_c (FC=0, always idle) taken decision mid-cycle.
    task automatic fwd_case(input string nm, input logic exp_tk);
        @(negedge clk);
        #1;
        check(nm, 32'(tk_c), 32'(exp_tk));
        check({nm, "_nop"}, 32'(nop_c), 32'(exp_tk));
        tick();
        clr();
        repeat (4) tick();
    endtask

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        clr();
        zero_seen();
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_nop", 32'(nop), 32'd0);
        check("reset_taken", 32'(tk), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count_b", 32'(fc_b), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single b: FC=1 gives 2 NOPs, FC=3 gives 4, FC=0 gives 1.
        zero_seen();
        b = 1'b1;
        @(negedge clk);
        #1;
        check("b_taken_a", 32'(tk_a), 32'd1);
        tick();
        b = 1'b0;
        repeat (5) tick();
        check("b_nops_a", 32'(nop_seen[0]), 32'd2);
        check("b_nops_b", 32'(nop_seen[1]), 32'd4);
        check("b_nops_c", 32'(nop_seen[2]), 32'd1);
        check("b_count_a", 32'(fc_a), 32'd1);

        // Forwarding cases.
        beq = 1'b1; ID_rs = 4'd3; ID_rt = 4'd5; rd1 = 16'h0010; rd2 = 16'h0020;
        EX_rt_rd = 4'd5; EX_reg_write = 1'b1; EX_alu_out = 16'h0010;
        fwd_case("beq_ex_fwd", 1'b1);
        beq = 1'b1; ID_rs = 4'd3; ID_rt = 4'd5; rd1 = 16'h0010; rd2 = 16'h0020;
        EX_rt_rd = 4'd5; EX_reg_write = 1'b0; EX_alu_out = 16'h0010;
        fwd_case("beq_no_fwd", 1'b0);
        bne = 1'b1; ID_rs = 4'd2; ID_rt = 4'd2; rd1 = 16'h2222; rd2 = 16'h2222;
        EX_rt_rd = 4'd2; EX_reg_write = 1'b1; EX_alu_out = 16'h1111;
        MEM_rt_rd = 4'd2; MEM_reg_write = 1'b1; MEM_result = 16'h2222;
        fwd_case("bne_ex_wins", 1'b0);
        bne = 1'b1; ID_rs = 4'd2; ID_rt = 4'd2; rd1 = 16'h2222; rd2 = 16'h2222;
        EX_rt_rd = 4'd0; EX_reg_write = 1'b1; EX_alu_out = 16'h1111;
        MEM_rt_rd = 4'd2; MEM_reg_write = 1'b1; MEM_result = 16'h2222;
        fwd_case("bne_mem_wins", 1'b0);
        beq = 1'b1; ID_rs = 4'd0; ID_rt = 4'd1; rd1 = 16'h0007; rd2 = 16'h0007;
        EX_rt_rd = 4'd0; EX_reg_write = 1'b1; EX_alu_out = 16'h0005;
        fwd_case("beq_r0_no_fwd", 1'b1);
        bne = 1'b1; ID_rs = 4'd1; ID_rt = 4'd4; rd1 = 16'h0001; rd2 = 16'h8001;
        fwd_case("bne_msb_diff", 1'b1);

        // FC=3 flush with two stalled cycles and an ignored beq during FLUSH.
        do_reset();
        zero_seen();
        bl = 1'b1;
        tick();
        bl = 1'b0; stall = 1'b1;
        tick();
        tick();
        stall = 1'b0; beq = 1'b1;
        tick();
        clr();
        repeat (4) tick();
        check("stall_nops_b", 32'(nop_seen[1]), 32'd6);
        check("stall_count_b", 32'(fc_b), 32'd1);

        // Reset in the middle of an FC=3 flush.
        b = 1'b1;
        tick();
        b = 1'b0;
        tick();
        check("pre_rst_busy_b", 32'(bz_b), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_nop_b", 32'(nop_b), 32'd0);
        check("mid_rst_busy_b", 32'(bz_b), 32'd0);
        check("mid_rst_count_b", 32'(fc_b), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        zero_seen();
        b = 1'b1;
        tick();
        clr();
        repeat (5) tick();
        check("post_rst_nops_b", 32'(nop_seen[1]), 32'd4);
        check("post_rst_count_b", 32'(fc_b), 32'd1);

        // CNT_W=2 saturation on the FC=0 instance.
        do_reset();
        b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("sat_count_%0d", k), 32'(fc_c), 32'(sat_exp[k]));
        end
        clr();
        tick();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int r;
            rst_n = ($urandom_range(0, 79) != 0);
            r = int'($urandom_range(0, 9));
            {b, bl, br, beq, bne} = '0;
            case (r)
                0: b = 1'b1;
                1: bl = 1'b1;
                2: br = 1'b1;
                3, 4: beq = 1'b1;
                5, 6: bne = 1'b1;
                7: {b, bl, br, beq, bne} = 5'($urandom);
                default: ;
            endcase
            stall = ($urandom_range(0, 3) == 0);
            ID_rs = 4'($urandom_range(0, 3));
            ID_rt = 4'($urandom_range(0, 3));
            EX_rt_rd = 4'($urandom_range(0, 3));
            MEM_rt_rd = 4'($urandom_range(0, 3));
            EX_reg_write = 1'($urandom);
            MEM_reg_write = 1'($urandom);
            rd1 = 16'($urandom_range(0, 2));
            rd2 = 16'($urandom_range(0, 2));
            EX_alu_out = 16'($urandom_range(0, 2));
            MEM_result = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom_range(0, 2));
            tick();
        end
        clr();
        rst_n = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_flush_ctrl.md
# pipeline_flush_ctrl

Parametrised branch-flush controller for the in-order pipeline. It resolves unconditional and conditional branches (beq/bne) in ID, using operand forwarding from EX and MEM, and asserts a synchronous NOP request on the IF/ID register. The request covers the resolving cycle plus a configurable number of follow-on cycles. It also honours pipeline stalls and keeps a saturating count of flushes for performance monitoring.

## Interface
Parameters:
- DATA_W, 16: register data width
- REG_W, 4: register-index width
- FLUSH_CYCLES, 1: extra flush cycles after the resolving cycle (0 allowed)
- CNT_W, 16: width of flush performance counter

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- b, bl, br  in  1 each  unconditional branch decoded in ID
- beq, bne  in  1 each  conditional branch decoded in ID
- stall  in  1  pipeline stall; ID contents held this cycle
- ID_rs, ID_rt  in  REG_W  source indices of branch in ID
- ID_read_data_1, ID_read_data_2  in  DATA_W  register-file values for rs, rt
- EX_rt_rd, MEM_rt_rd  in  REG_W  destination index in EX, MEM
- EX_reg_write, MEM_reg_write  in  1  destination valid in EX, MEM
- EX_alu_out, MEM_result  in  DATA_W  forwardable results
- IF_ID_sync_nop  out  1  insert NOP into IF/ID this cycle
- branch_taken  out  1  one-cycle pulse on accepted taken branch
- flush_busy  out  1  high while in FLUSH state
- flush_count  out  CNT_W  saturating count of accepted taken branches

## Operation
- Operand resolution, independent for each of rs and rt:
  - EX forward if EX_reg_write and EX_rt_rd == index and index != 0.
  - Else MEM forward under the same rule.
  - Else register-file value.
  - EX has priority over MEM.
- eq = (opA == opB), full DATA_W compare.
- take = b | bl | br | (beq & eq) | (bne & ~eq). Exactly one decode input is high at a time; with several high, the OR still applies.
- States:
  - IDLE: accepted = take & ~stall & (state == IDLE). On accept, go to FLUSH with cnt = FLUSH_CYCLES. If FLUSH_CYCLES == 0, stay in IDLE.
  - FLUSH: decode inputs are ignored (ID holds a bubble). While ~stall, cnt decrements. When cnt == 1 and ~stall, return to IDLE. stall freezes cnt and state.
- IF_ID_sync_nop = accepted | (state == FLUSH), purely combinational.
- branch_taken = accepted. flush_busy = (state == FLUSH).
- flush_count increments on accepted and saturates at all-ones.
- cnt width is $clog2(FLUSH_CYCLES+1), minimum 1.

## Timing
- Reset (async assert, sync release): state IDLE, cnt 0, flush_count 0. With decode inputs low, all outputs are 0.
- Reset mid-flush aborts immediately; IF_ID_sync_nop drops in the same cycle rst_n falls.
- Latency: the NOP is visible in the resolving cycle (0-cycle), then for exactly FLUSH_CYCLES further non-stalled cycles. Total NOP cycles = 1 + FLUSH_CYCLES + stalled cycles inside FLUSH.
- A stall in the resolving cycle produces no accept and no NOP. The branch re-evaluates on the first non-stalled cycle.
- A branch arriving in the cycle FLUSH ends (state still FLUSH) is ignored. It can only be accepted from IDLE on the next cycle.
- Forwarded index 0 is never forwarded; r0 reads the register file.
- Counter saturation: at all-ones, an accepted branch leaves flush_count unchanged.

## Structure
- Shared package `pipeline_pkg`: REG_W and DATA_W defaults, state enum {IDLE, FLUSH}, and the branch-decode bundle constants (`macro_defines.v` entries for the b/bl/br/beq/bne opcodes).
- Sub-module `branch_operand_fwd`, instantiated twice (rs, rt): a purely combinational forward mux, REG_W/DATA_W parametrised.
- Top module holds the FSM, flush counter and performance counter.

## Test plan
- FLUSH_CYCLES=1, b=1 for one cycle → IF_ID_sync_nop high 2 cycles, branch_taken 1 cycle, flush_count 0→1.
- beq, rs=3, rt=5, ID_read_data_1=0x0010, ID_read_data_2=0x0020, EX writes r5 with EX_alu_out=0x0010 → taken; with EX_reg_write=0 → not taken, no NOP.
- bne, rs=rt=2, EX and MEM both write r2 (EX=0x1111, MEM=0x2222), ID_read_data=0x2222 → EX wins, eq=1, not taken. With EX_rt_rd=0, MEM wins → not taken.
- FLUSH_CYCLES=3, bl accepted, stall high 2 cycles during FLUSH → NOP high 6 cycles total. A beq taken during FLUSH is ignored (flush_count +1 only).
- rst_n low in the middle of a FLUSH_CYCLES=3 flush → outputs 0 immediately, flush_count 0. After release, b → normal 4-cycle flush.
- CNT_W=2, five accepted branches → flush_count 1,2,3,3,3.
